mem_dump_engine: RTL and testbench
==================================

Name: mem_dump_engine

Overview:
- RTL-side reader that walks a range of the memory array through its synchronous read port and streams (address, data) beats to the bench or debug logic over a valid/ready interface.
- Counterpart to the reset-time memory override path, which writes memory in bulk. This block reads memory back out while the design runs, for dump and compare against the memory model.
- Sits between the main RAM read port (muxed in while busy) and a debug sink.

Parameters:
- REG_WIDTH, 8, data word width (matches `REG_WIDTH).
- MEM_DEPTH, 2048, number of words in the array (matches `MEM_DEPTH).
- ADDR_WIDTH, $clog2(MEM_DEPTH), word address width.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE
- start_addr  in  ADDR_WIDTH  first address, inclusive
- end_addr  in  ADDR_WIDTH+1  last address, exclusive; MEM_DEPTH is legal
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the dump completes or is rejected
- err_range  out  1  one-cycle pulse, coincident with done, on an illegal range
- mem_rd_en  out  1  read strobe to RAM
- mem_rd_addr  out  ADDR_WIDTH  read address
- mem_rd_data  in  REG_WIDTH  RAM data, valid the cycle after mem_rd_en
- out_valid  out  1  beat available
- out_ready  in  1  sink accepts beat
- out_addr  out  ADDR_WIDTH  address of current beat
- out_data  out  REG_WIDTH  data of current beat

Behaviour:
- Reset (reset_n low at a clock edge):
  - state=IDLE; busy, done, err_range, mem_rd_en, out_valid = 0; mem_rd_addr, out_addr, out_data = 0.
  - Buffer is emptied and any in-flight read is discarded.
  - Reset mid-dump aborts with no done pulse.
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - start=1 with legal range (start_addr < end_addr and end_addr <= MEM_DEPTH): latch rd_ptr=start_addr and end, then go to RUN.
  - start=1 with illegal range: pulse done and err_range the next cycle, stay in IDLE, issue no reads.
  - start is ignored in every state except IDLE.
- RUN:
  - Assert mem_rd_en with mem_rd_addr=rd_ptr whenever (buf_count + inflight - pop) < 2, where pop = out_valid & out_ready this cycle.
  - Increment rd_ptr on each issued read.
  - When the read at end-1 is issued, go to DRAIN.
- Read data capture: the read issued in cycle C returns mem_rd_data in cycle C+1. It is written into a 2-entry FIFO, together with its address, at the end of C+1.
- Output timing:
  - out_valid = FIFO non-empty; out_addr/out_data = FIFO head.
  - First beat is visible 3 cycles after the start cycle.
  - With out_ready held high, sustained throughput is 1 beat per cycle.
- Output hold rule: once out_valid is high, out_addr and out_data are held stable until out_ready. out_valid never drops without a handshake.
- DRAIN: no reads issued. When the FIFO is empty and nothing is in flight, go to FIN.
- FIN: done=1 for one cycle, busy=0, return to IDLE. A new start is accepted the cycle after FIN.
- busy: 1 in RUN and DRAIN, 0 in IDLE and FIN.
- Single-word range (end = start+1): one read, directly to DRAIN.
- Full range (0..MEM_DEPTH): rd_ptr reaches end without wrap. The end compare uses ADDR_WIDTH+1 bits.
- Backpressure: with out_ready held low, at most 2 reads are outstanding or buffered. No data is lost or duplicated.
- Simultaneous push and pop on a full FIFO is legal; the count is unchanged.

Decomposition:
- Package mem_dbg_pkg holds:
  - dump_state_t enum {IDLE, RUN, DRAIN, FIN};
  - localparam DUMP_BUF_DEPTH=2;
  - typedef dump_beat_t struct {addr, data}.
- Sub-module mem_dump_fifo: 2-entry synchronous FIFO of dump_beat_t with push/pop/count, and the same synchronous active-low reset.

Test Plan:
- Preload mem[0..7]=8'h10..8'h17, start_addr=0, end_addr=8, out_ready=1:
  - 8 beats, addr 0..7, data 10..17, on consecutive cycles starting 3 cycles after start;
  - done pulses once after the last beat;
  - busy is high for exactly that window.
- Same range, out_ready toggling 1-0-0-1 repeating:
  - all 8 beats arrive in order with no drop or duplicate;
  - out_data is stable while out_ready=0;
  - mem_rd_en never leaves more than 2 reads outstanding or buffered.
- start_addr=5, end_addr=5, then start_addr=0, end_addr=MEM_DEPTH+1:
  - each gives done and err_range on the next cycle;
  - mem_rd_en stays 0 and busy stays 0.
- start_addr=MEM_DEPTH-1, end_addr=MEM_DEPTH: exactly one beat, addr=MEM_DEPTH-1, then done.
- Second start pulse issued mid-dump: ignored; beat count equals the first range only.
- reset_n driven low for 1 cycle during the 4th beat of a 0..8 dump:
  - all outputs return to 0 and no done pulse occurs;
  - a fresh start then produces a clean 8-beat dump.

Source files
------------

// File: rtl/mem_dbg_pkg.sv
// Shared types for the memory dump engine: FSM states, buffer depth and beat layout.
package mem_dbg_pkg;

  localparam int DUMP_REG_WIDTH  = 8;
  localparam int DUMP_MEM_DEPTH  = 2048;
  localparam int DUMP_ADDR_WIDTH = $clog2(DUMP_MEM_DEPTH);
  localparam int DUMP_BUF_DEPTH  = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } dump_state_t;

  typedef struct packed {
    logic [DUMP_ADDR_WIDTH-1:0] addr;
    logic [DUMP_REG_WIDTH-1:0]  data;
  } dump_beat_t;

endpackage

// File: rtl/mem_dump_fifo.sv
// Two-entry beat buffer between the RAM read return and the debug sink.
// A push on a full buffer is only taken when a pop happens in the same cycle.
module mem_dump_fifo
  import mem_dbg_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  dump_beat_t push_beat,
  input  logic       pop,
  output dump_beat_t head,
  output logic [1:0] count
);

  localparam logic [1:0] FULL_COUNT = 2'(DUMP_BUF_DEPTH);

  dump_beat_t entry_q [DUMP_BUF_DEPTH];
  logic       wr_idx_q;
  logic       rd_idx_q;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != FULL_COUNT) || do_pop);
  assign head    = entry_q[rd_idx_q];

  // Storage, pointers and occupancy; reset clears contents so the head reads as zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DUMP_BUF_DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      wr_idx_q <= 1'b0;
      rd_idx_q <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (do_push) begin
        entry_q[wr_idx_q] <= push_beat;
        wr_idx_q          <= ~wr_idx_q;
      end
      if (do_pop) begin
        rd_idx_q <= ~rd_idx_q;
      end
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/mem_dump_engine.sv
// Walks [start_addr, end_addr) through the RAM's synchronous read port and streams
// (address, data) beats to a valid/ready sink, never holding more than two reads
// outstanding or buffered so backpressure cannot lose data.
module mem_dump_engine
  import mem_dbg_pkg::*;
#(
  parameter int REG_WIDTH  = DUMP_REG_WIDTH,
  parameter int MEM_DEPTH  = DUMP_MEM_DEPTH,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   end_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err_range,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [REG_WIDTH-1:0]  mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [REG_WIDTH-1:0]  out_data
);

  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  dump_state_t           state_q;
  dump_state_t           state_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q;
  logic [ADDR_WIDTH:0]   end_q;
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] inflight_addr_q;
  logic                  reject_q;
  logic                  accept;
  logic                  reject;
  logic                  range_ok;
  logic                  pop;
  logic                  room;
  logic [2:0]            occupancy;
  logic [1:0]            fifo_count;
  dump_beat_t            fifo_head;
  dump_beat_t            push_beat;

  // The pointer carries one extra bit so a range ending at MEM_DEPTH terminates without wrapping.
  assign range_ok    = ({1'b0, start_addr} < end_addr) && (end_addr <= DEPTH_EXT);
  assign pop         = out_valid && out_ready;
  assign occupancy   = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
  assign room        = occupancy < 3'd2;
  assign mem_rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];
  assign push_beat   = '{addr: inflight_addr_q, data: mem_rd_data};
  assign out_valid   = fifo_count != 2'd0;
  assign out_addr    = fifo_head.addr;
  assign out_data    = fifo_head.data;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, read strobe and status outputs; a rejected range reports from IDLE one cycle later.
  always_comb begin
    state_d   = state_q;
    mem_rd_en = 1'b0;
    busy      = 1'b0;
    done      = reject_q;
    err_range = reject_q;
    accept    = 1'b0;
    reject    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (range_ok) begin
            accept  = 1'b1;
            state_d = RUN;
          end else begin
            reject = 1'b1;
          end
        end
      end
      RUN: begin
        busy      = 1'b1;
        mem_rd_en = room;
        if (room && ((rd_ptr_q + PTR_ONE) == end_q)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if ((fifo_count == 2'd0) && !inflight_q) begin
          state_d = FIN;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read pointer, range end, and tracking of the single read whose data returns next cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_q        <= '0;
      end_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      reject_q        <= 1'b0;
    end else begin
      reject_q   <= reject;
      inflight_q <= mem_rd_en;
      if (mem_rd_en) begin
        inflight_addr_q <= rd_ptr_q[ADDR_WIDTH-1:0];
        rd_ptr_q        <= rd_ptr_q + PTR_ONE;
      end
      if (accept) begin
        rd_ptr_q <= {1'b0, start_addr};
        end_q    <= end_addr;
      end
    end
  end

  mem_dump_fifo u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (inflight_q),
    .push_beat (push_beat),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_mem_dump_engine.sv
// Self-checking bench for mem_dump_engine: a RAM model feeds the read port and a
// queue of expected (address, data) beats is built straight from the requested range.
module tb_mem_dump_engine;
  import mem_dbg_pkg::*;

  localparam int REG_WIDTH  = DUMP_REG_WIDTH;
  localparam int MEM_DEPTH  = DUMP_MEM_DEPTH;
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  start = 1'b0;
  logic [ADDR_WIDTH-1:0] start_addr = '0;
  logic [ADDR_WIDTH:0]   end_addr = '0;
  logic                  busy;
  logic                  done;
  logic                  err_range;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [REG_WIDTH-1:0]  mem_rd_data = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [REG_WIDTH-1:0]  out_data;

  logic [REG_WIDTH-1:0]  mem [MEM_DEPTH];
  dump_beat_t            exp_q [$];

  int n_checks = 0;
  int n_fail = 0;
  int cycle = 0;
  int ready_mode = 0;
  int ready_phase = 0;
  int start_cycle = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int busy_cnt = 0;
  int rd_cnt = 0;
  int beats_seen = 0;
  int first_beat = -1;
  int last_beat = -1;
  int done_cycle = -1;
  int busy_first = -1;
  int issued = 0;
  int popped = 0;
  bit hold_pending = 1'b0;
  logic [ADDR_WIDTH-1:0] hold_addr = '0;
  logic [REG_WIDTH-1:0]  hold_data = '0;

  mem_dump_engine dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .start_addr  (start_addr),
    .end_addr    (end_addr),
    .busy        (busy),
    .done        (done),
    .err_range   (err_range),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_data    (out_data)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Cycle counter and sink readiness: 0 = always ready, 1 = 1-0-0-1 pattern, 2 = random.
  initial begin
    forever begin
      @(posedge clk);
      cycle++;
      ready_phase++;
      #1;
      case (ready_mode)
        1: out_ready = ((ready_phase % 4) == 0) || ((ready_phase % 4) == 3);
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: beat order/content, hold rule, outstanding-read bound and event counters.
  initial begin
    dump_beat_t e;
    bit p;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        issued = 0;
        popped = 0;
        hold_pending = 1'b0;
      end else begin
        p = out_valid && out_ready;
        if (hold_pending) begin
          checkOutput("hold_valid", 32'(out_valid), 32'd1);
          checkOutput("hold_addr", 32'(out_addr), 32'(hold_addr));
          checkOutput("hold_data", 32'(out_data), 32'(hold_data));
        end
        if (p) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_beat", 32'(out_addr), 32'hffff_ffff);
          end else begin
            e = exp_q.pop_front();
            checkOutput("beat_addr", 32'(out_addr), 32'(e.addr));
            checkOutput("beat_data", 32'(out_data), 32'(e.data));
          end
          beats_seen++;
          if (first_beat < 0) first_beat = cycle;
          last_beat = cycle;
        end
        if (mem_rd_en) begin
          checkOutput("outstanding_le2", 32'((issued + 1 - popped - int'(p)) <= 2), 32'd1);
          rd_cnt++;
        end
        if (done) begin
          done_cnt++;
          done_cycle = cycle;
          checkOutput("busy_at_done", 32'(busy), 32'd0);
        end
        if (err_range) err_cnt++;
        if (busy) begin
          busy_cnt++;
          if (busy_first < 0) busy_first = cycle;
        end
        issued = issued + int'(mem_rd_en);
        popped = popped + int'(p);
        hold_pending = out_valid && !out_ready;
        hold_addr = out_addr;
        hold_data = out_data;
      end
    end
  end

  task automatic clearCounters();
    done_cnt = 0;
    err_cnt = 0;
    busy_cnt = 0;
    rd_cnt = 0;
    beats_seen = 0;
    first_beat = -1;
    last_beat = -1;
    done_cycle = -1;
    busy_first = -1;
  endtask

  task automatic buildExpected(input int sa, input int ea);
    exp_q.delete();
    for (int a = sa; a < ea; a++) begin
      exp_q.push_back('{addr: ADDR_WIDTH'(a), data: mem[a]});
    end
  endtask

  // One dump request; restart_at > 0 fires a second start that many cycles in.
  task automatic applyStimulus(input int sa, input int ea, input int mode, input int restart_at);
    bit legal;
    int len;
    int bound;
    int k;
    legal = (sa < ea) && (ea <= MEM_DEPTH);
    len = legal ? (ea - sa) : 0;
    if (legal) buildExpected(sa, ea);
    else exp_q.delete();
    ready_mode = mode;
    clearCounters();
    @(posedge clk); #1;
    start = 1'b1;
    start_addr = ADDR_WIDTH'(sa);
    end_addr = (ADDR_WIDTH+1)'(ea);
    start_cycle = cycle;
    @(posedge clk); #1;
    start = 1'b0;
    k = 1;
    bound = 4 * len + 40;
    while (done_cnt == 0 && k < bound) begin
      if (k == restart_at) begin
        start = 1'b1;
        start_addr = '0;
        end_addr = (ADDR_WIDTH+1)'(100);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_count", 32'(done_cnt), 32'd1);
    checkOutput("err_count", 32'(err_cnt), legal ? 32'd0 : 32'd1);
    if (legal) begin
      checkOutput("beat_count", 32'(beats_seen), 32'(len));
      checkOutput("beats_left", 32'(exp_q.size()), 32'd0);
      checkOutput("done_after_last", 32'(done_cycle > last_beat), 32'd1);
      checkOutput("busy_first", 32'(busy_first), 32'(start_cycle + 1));
      checkOutput("busy_window", 32'(busy_cnt), 32'(done_cycle - start_cycle - 1));
      if (mode == 0) begin
        checkOutput("first_beat_cycle", 32'(first_beat), 32'(start_cycle + 3));
        checkOutput("last_beat_cycle", 32'(last_beat), 32'(start_cycle + 2 + len));
        checkOutput("done_cycle", 32'(done_cycle), 32'(start_cycle + len + 4));
      end
    end else begin
      checkOutput("reject_done_cycle", 32'(done_cycle), 32'(start_cycle + 1));
      checkOutput("reject_reads", 32'(rd_cnt), 32'd0);
      checkOutput("reject_busy", 32'(busy_cnt), 32'd0);
      checkOutput("reject_beats", 32'(beats_seen), 32'd0);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_err"}, 32'(err_range), 32'd0);
    checkOutput({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
    checkOutput({tag, "_rd_addr"}, 32'(mem_rd_addr), 32'd0);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_out_addr"}, 32'(out_addr), 32'd0);
    checkOutput({tag, "_out_data"}, 32'(out_data), 32'd0);
  endtask

  // Reset pulse landing on the fourth beat of a 0..8 dump.
  task automatic resetMidDump();
    buildExpected(0, 8);
    ready_mode = 0;
    clearCounters();
    @(posedge clk); #1;
    start = 1'b1;
    start_addr = '0;
    end_addr = (ADDR_WIDTH+1)'(8);
    start_cycle = cycle;
    @(posedge clk); #1;
    start = 1'b0;
    while (cycle < start_cycle + 6) begin
      @(posedge clk); #1;
    end
    checkOutput("pre_reset_beats", 32'(beats_seen), 32'd3);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    checkIdleOutputs("mid_reset");
    exp_q.delete();
    clearCounters();
    repeat (12) @(posedge clk);
    #1;
    checkOutput("no_done_after_reset", 32'(done_cnt), 32'd0);
    checkOutput("no_busy_after_reset", 32'(busy_cnt), 32'd0);
    checkOutput("no_beats_after_reset", 32'(beats_seen), 32'd0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sa;
    int ea;
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = REG_WIDTH'($urandom);
    for (int i = 0; i < 8; i++) mem[i] = REG_WIDTH'(8'h10 + i);

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    checkIdleOutputs("reset");

    $display("[TB] streaming 0..8 with sink always ready");
    applyStimulus(0, 8, 0, 0);
    $display("[TB] streaming 0..8 with 1-0-0-1 backpressure");
    applyStimulus(0, 8, 1, 0);
    $display("[TB] illegal ranges");
    applyStimulus(5, 5, 0, 0);
    applyStimulus(0, MEM_DEPTH + 1, 0, 0);
    $display("[TB] last word only");
    applyStimulus(MEM_DEPTH - 1, MEM_DEPTH, 0, 0);
    $display("[TB] second start while busy");
    applyStimulus(0, 8, 0, 5);
    $display("[TB] reset during dump");
    resetMidDump();
    applyStimulus(0, 8, 0, 0);
    $display("[TB] full array");
    applyStimulus(0, MEM_DEPTH, 0, 0);
    $display("[TB] random ranges and backpressure");
    for (int n = 0; n < 10; n++) begin
      sa = int'($urandom_range(0, MEM_DEPTH - 1));
      ea = sa + int'($urandom_range(1, 24));
      if (ea > MEM_DEPTH) ea = MEM_DEPTH;
      if ($urandom_range(0, 4) == 0) ea = sa;
      applyStimulus(sa, ea, int'($urandom_range(0, 2)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
